// File: rtl/dac_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_serializer_if
// Brief    : Sample handshake and codec-side serial signals for dac_serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_serializer_if;
    logic        DACLRCK;
    logic [31:0] DACDAT_PAR;
    logic        PAR_VALID;
    logic        PAR_READY;
    logic        DACDAT;
    logic        UNDERRUN;
    logic        FRAME_ERR;

    modport master (
        output DACLRCK, DACDAT_PAR, PAR_VALID,
        input  PAR_READY, DACDAT, UNDERRUN, FRAME_ERR
    );

    modport slave (
        input  DACLRCK, DACDAT_PAR, PAR_VALID,
        output PAR_READY, DACDAT, UNDERRUN, FRAME_ERR
    );
endinterface
`default_nettype wire

// File: rtl/dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dac_serializer
// Brief    : Serialises 32-bit stereo words MSB-first onto DACDAT, framed by
//            DACLRCK, with a one-entry holding register and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dac_serializer (
    input  wire logic       BCLK,
    input  wire logic       RESET,
    dac_serializer_if.slave dac_if
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEFT  = 3'd1;
    localparam logic [2:0] c_GAP_L = 3'd2;
    localparam logic [2:0] c_RIGHT = 3'd3;
    localparam logic [2:0] c_GAP_R = 3'd4;

    // Count value held while the 16th bit of a channel is being driven out.
    localparam logic [4:0] c_LAST_BIT = 5'd15;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_lrck_q;
    logic [31:0] r_shift;
    logic [31:0] w_shift_nxt;
    logic [4:0]  r_count;
    logic [4:0]  w_count_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic        r_full;
    logic        w_full_nxt;
    logic        r_dacdat;
    logic        w_dacdat_nxt;
    logic        r_ready;
    logic        r_underrun;
    logic        w_underrun_nxt;
    logic        r_frame_err;
    logic        w_frame_err_nxt;
    logic [31:0] w_word;
    logic        w_rise;
    logic        w_fall;
    logic        w_hs;

    assign w_rise = dac_if.DACLRCK & ~r_lrck_q;
    assign w_fall = ~dac_if.DACLRCK & r_lrck_q;
    assign w_hs   = dac_if.PAR_VALID & r_ready;

    always_ff @(posedge BCLK) begin
        if (RESET) begin
            r_state     <= c_IDLE;
            r_lrck_q    <= dac_if.DACLRCK;
            r_shift     <= 32'h0;
            r_count     <= 5'd0;
            r_hold      <= 32'h0;
            r_full      <= 1'b0;
            r_dacdat    <= 1'b0;
            r_ready     <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lrck_q    <= dac_if.DACLRCK;
            r_shift     <= w_shift_nxt;
            r_count     <= w_count_nxt;
            r_hold      <= w_hold_nxt;
            r_full      <= w_full_nxt;
            r_dacdat    <= w_dacdat_nxt;
            r_ready     <= ~w_full_nxt;
            r_underrun  <= w_underrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise) begin
            w_state_nxt = c_LEFT;
        end else begin
            case (r_state)
                c_LEFT: begin
                    if (w_fall)
                        w_state_nxt = c_RIGHT;
                    else if (r_count == c_LAST_BIT)
                        w_state_nxt = c_GAP_L;
                end
                c_GAP_L: begin
                    if (w_fall)
                        w_state_nxt = c_RIGHT;
                end
                c_RIGHT: begin
                    if (r_count == c_LAST_BIT)
                        w_state_nxt = c_GAP_R;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Left half is pre-shifted at load so bit 31 always holds the next left
    // bit; the right half stays intact until the channel switch.
    always_comb begin
        w_shift_nxt     = r_shift;
        w_count_nxt     = r_count;
        w_hold_nxt      = r_hold;
        w_full_nxt      = r_full;
        w_dacdat_nxt    = 1'b0;
        w_underrun_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_word          = 32'h0;
        if (w_rise) begin
            w_frame_err_nxt = (r_state == c_LEFT) || (r_state == c_GAP_L) ||
                              (r_state == c_RIGHT);
            if (r_full) begin
                w_word     = r_hold;
                w_full_nxt = 1'b0;
            end else if (w_hs) begin
                w_word = dac_if.DACDAT_PAR;
            end else begin
                w_underrun_nxt = 1'b1;
            end
            w_shift_nxt  = {w_word[30:16], 1'b0, w_word[15:0]};
            w_dacdat_nxt = w_word[31];
            w_count_nxt  = 5'd1;
        end else begin
            if (w_hs) begin
                w_hold_nxt = dac_if.DACDAT_PAR;
                w_full_nxt = 1'b1;
            end
            case (r_state)
                c_LEFT, c_GAP_L: begin
                    if (w_fall) begin
                        w_frame_err_nxt   = (r_state == c_LEFT);
                        w_dacdat_nxt      = r_shift[15];
                        w_shift_nxt[15:0] = {r_shift[14:0], 1'b0};
                        w_count_nxt       = 5'd1;
                    end else if (r_state == c_LEFT) begin
                        w_dacdat_nxt       = r_shift[31];
                        w_shift_nxt[31:16] = {r_shift[30:16], 1'b0};
                        w_count_nxt        = r_count + 5'd1;
                    end
                end
                c_RIGHT: begin
                    w_dacdat_nxt      = r_shift[15];
                    w_shift_nxt[15:0] = {r_shift[14:0], 1'b0};
                    w_count_nxt       = r_count + 5'd1;
                end
                default: w_dacdat_nxt = 1'b0;
            endcase
        end
    end

    assign dac_if.DACDAT    = r_dacdat;
    assign dac_if.PAR_READY = r_ready;
    assign dac_if.UNDERRUN  = r_underrun;
    assign dac_if.FRAME_ERR = r_frame_err;

endmodule
`default_nettype wire
